// File: rtl/btn_cmd_gen.sv
// Pushbutton command generator: synchronizes and debounces three raw buttons,
// turns debounced presses into timer commands, and waits for the timer to
// acknowledge each command before it accepts the next press.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   btn_start  raw start button (async, active-high)
//   btn_stop   raw stop button (async, active-high)
//   btn_reset  raw stop-and-reset button (async, active-high)
//   state      timer state: 00 INIT, 01 START, 10 STOP, 11 STOP_RESET
//   cmd        registered command: 00 none, 01 start, 10 stop, 11 stop-and-reset
//   busy       high while a command is issued or awaiting acknowledge
//   drop       one-cycle pulse when press events are discarded
//   timeout    one-cycle pulse when a command is not acknowledged in time
module btn_cmd_gen #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_reset,
    input  logic [1:0] state,
    output logic [1:0] cmd,
    output logic       busy,
    output logic       drop,
    output logic       timeout
);

    localparam int unsigned CW   = 8;
    localparam int unsigned NBTN = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_RST   = 2'b11;

    localparam logic [1:0] T_INIT  = 2'b00;
    localparam logic [1:0] T_START = 2'b01;
    localparam logic [1:0] T_STOP  = 2'b10;
    localparam logic [1:0] T_RST   = 2'b11;

    // Bit order: [0] start, [1] stop, [2] reset
    logic [NBTN-1:0] w_btn;
    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [NBTN-1:0] r_deb;
    logic [NBTN-1:0] r_press;
    logic [CW-1:0]   r_cnt [NBTN];

    logic [1:0]    r_fsm,  w_fsm_nxt;
    logic [1:0]    r_cmd,  w_cmd_nxt;
    logic [1:0]    r_kind, w_kind_nxt;
    logic [CW-1:0] r_wcnt, w_wcnt_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_drop, w_drop_nxt;
    logic          r_to,   w_to_nxt;

    logic [1:0] w_req;
    logic       w_multi;
    logic       w_legal;
    logic       w_ack;

    assign w_btn = {btn_reset, btn_stop, btn_start};

    // Synchronizers and debouncers; r_press is a one-cycle pulse on a debounced rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_press <= '0;
            for (int i = 0; i < NBTN; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NBTN; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        r_deb[i]   <= r_sync2[i];
                        r_cnt[i]   <= '0;
                        r_press[i] <= r_sync2[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Priority reset > stop > start, legality of the winner, and acknowledge match
    always_comb begin
        w_req   = CMD_NONE;
        w_legal = 1'b0;
        w_ack   = 1'b0;
        w_multi = (r_press[0] & r_press[1]) | (r_press[0] & r_press[2]) |
                  (r_press[1] & r_press[2]);
        if (r_press[2])      w_req = CMD_RST;
        else if (r_press[1]) w_req = CMD_STOP;
        else if (r_press[0]) w_req = CMD_START;
        case (w_req)
            CMD_START: w_legal = (state == T_INIT) || (state == T_STOP);
            CMD_STOP:  w_legal = (state == T_START);
            CMD_RST:   w_legal = (state == T_START) || (state == T_STOP);
            default:   w_legal = 1'b0;
        endcase
        case (r_kind)
            CMD_START: w_ack = (state == T_START);
            CMD_STOP:  w_ack = (state == T_STOP);
            CMD_RST:   w_ack = (state == T_RST) || (state == T_INIT);
            default:   w_ack = 1'b0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_cmd_nxt  = CMD_NONE;
        w_kind_nxt = r_kind;
        w_wcnt_nxt = r_wcnt;
        w_busy_nxt = 1'b0;
        w_drop_nxt = 1'b0;
        w_to_nxt   = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (w_req != CMD_NONE) begin
                    if (w_legal) begin
                        w_cmd_nxt  = w_req;
                        w_kind_nxt = w_req;
                        w_busy_nxt = 1'b1;
                        w_drop_nxt = w_multi;
                        w_fsm_nxt  = S_ISSUE;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_drop_nxt = |r_press;
                w_busy_nxt = 1'b1;
                w_wcnt_nxt = '0;
                w_fsm_nxt  = S_WAIT;
            end
            S_WAIT: begin
                w_drop_nxt = |r_press;
                if (w_ack) begin
                    w_fsm_nxt = S_IDLE;
                end else if (r_wcnt == CW'(ACK_TIMEOUT - 1)) begin
                    w_to_nxt  = 1'b1;
                    w_fsm_nxt = S_IDLE;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_wcnt_nxt = r_wcnt + CW'(1);
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm  <= S_IDLE;
            r_cmd  <= CMD_NONE;
            r_kind <= CMD_NONE;
            r_wcnt <= '0;
            r_busy <= 1'b0;
            r_drop <= 1'b0;
            r_to   <= 1'b0;
        end else begin
            r_fsm  <= w_fsm_nxt;
            r_cmd  <= w_cmd_nxt;
            r_kind <= w_kind_nxt;
            r_wcnt <= w_wcnt_nxt;
            r_busy <= w_busy_nxt;
            r_drop <= w_drop_nxt;
            r_to   <= w_to_nxt;
        end
    end

    assign cmd     = r_cmd;
    assign busy    = r_busy;
    assign drop    = r_drop;
    assign timeout = r_to;

endmodule
